ldtu_fsm_param: RTL and testbench
=================================

LDTU_FSM_PARAM -- requirements
Module: ldtu_fsm_param

Interface
REQ-001 Parameter BAS_RUN, default 5: baseline words per baseline group (range 2..16).
REQ-002 Parameter SIG_RUN, default 2: signal words per signal group (range 2..16).
REQ-003 Parameter FB_LAT, default 1: idle (latency) cycles between fallback data words (range 1..7).
REQ-004 Parameter OCW, default 12: orbit counter width.
REQ-005 Port CLK, input, 1: block clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: synchronous reset, active-high.
REQ-007 Port fallback, input, 1: 1 selects the fallback FSM; 0 selects the encoding FSM.
REQ-008 Port Orbit, input, 1: BC0 marker; 1 requests header insertion.
REQ-009 Port baseline_flag, input, 1: 1 means the current sample fits the baseline width.
REQ-010 Port state, output, 4: encoding-FSM state code, taken from the shared package.
REQ-011 Port word_idx, output, 4: position within the current baseline or signal group.
REQ-012 Port fb_state, output, 3: fallback-FSM state code.
REQ-013 Port fb_lat_cnt, output, 3: elapsed latency cycles in fallback.
REQ-014 Port orbit_cnt, output, OCW: count of accepted Orbit markers, wrapping modulo 2^OCW.
REQ-015 Port seu_error, output, 1: one-cycle pulse when an illegal state code or index is detected.

Function
REQ-016 Encoding states SHALL be: IDLE, BAS, BAS_BIS, SIGN, SIGN_BIS, BC0, BC0_S, BC0_BIS, HDR, HDR_S, HDR_B.
REQ-017 Encoding-FSM transitions from IDLE SHALL be:
- Orbit=1 -> HDR.
- Otherwise baseline_flag=1 -> BAS with idx 0.
- Otherwise -> SIGN with idx 0.
REQ-018 Transitions from BAS at idx k SHALL be:
- Orbit=1 -> BC0.
- Otherwise flag=1 -> BAS with idx (k+1) mod BAS_RUN.
- Otherwise -> BAS_BIS.
REQ-019 Transitions from BAS_BIS SHALL be:
- Orbit=1 -> BC0_BIS.
- Otherwise flag=1 -> SIGN_BIS.
- Otherwise -> SIGN with idx 0.
REQ-020 Transitions from SIGN at idx k<SIG_RUN-1 SHALL be:
- Orbit=1 -> BC0_S.
- Otherwise flag=0 -> SIGN with idx k+1.
- Otherwise -> SIGN_BIS.
REQ-021 Transitions from SIGN at idx SIG_RUN-1 SHALL be:
- Orbit=1 -> BC0_BIS.
- Otherwise flag=0 -> SIGN with idx 0.
- Otherwise -> SIGN_BIS.
REQ-022 Transitions from SIGN_BIS SHALL be:
- Orbit=1 -> BC0.
- Otherwise flag=0 -> BAS_BIS.
- Otherwise -> BAS with idx 0.
REQ-023 Transitions from the header states SHALL be:
- BC0 and BC0_BIS: flag=0 -> HDR_S, else -> HDR_B.
- BC0_S -> HDR unconditionally.
- HDR: flag=0 -> SIGN idx 0, else -> BAS idx 0.
- HDR_S: flag=0 -> SIGN idx 0, else -> SIGN_BIS.
- HDR_B: flag=0 -> BAS_BIS, else -> BAS idx 0.
REQ-024 Orbit SHALL be ignored while in BC0, BC0_S, BC0_BIS, HDR, HDR_S or HDR_B.
REQ-025 word_idx SHALL be 0 in every state other than BAS and SIGN.
REQ-026 Outputs SHALL be registered, with one cycle of latency from input to state.
REQ-027 orbit_cnt SHALL increment on the cycle the FSM enters BC0, BC0_S, BC0_BIS, or enters HDR from IDLE.
REQ-028 An Orbit that is ignored per REQ-024 SHALL NOT increment orbit_cnt.
REQ-029 An undefined state code, or word_idx at or above the run length, SHALL force IDLE with idx 0 on the next cycle and pulse seu_error for 1 cycle.
REQ-030 While fallback=1, state SHALL be held at IDLE.
REQ-031 Fallback-FSM states SHALL be FB_IDLE, DATA_ODD, LAT1, DATA_EVEN, LAT2.
REQ-032 Fallback-FSM transitions SHALL be:
- FB_IDLE -> DATA_ODD.
- DATA_ODD -> LAT1.
- LAT1 holds for FB_LAT cycles, then -> DATA_EVEN.
- DATA_EVEN -> LAT2.
- LAT2 holds for FB_LAT cycles, then -> DATA_ODD.
REQ-033 fb_lat_cnt SHALL count 0..FB_LAT-1 in LAT1 and LAT2, and be 0 in all other states.
REQ-034 While fallback=0, the fallback FSM SHALL be held at FB_IDLE.
REQ-035 A change of fallback mid-group SHALL abandon the active FSM at the next edge; no partial group resumes.

Reset
REQ-036 On reset=1 at a clock edge, the following SHALL be cleared:
- state=IDLE, word_idx=0.
- fb_state=FB_IDLE, fb_lat_cnt=0.
- orbit_cnt=0, seu_error=0.
REQ-037 Reset SHALL take priority over fallback, Orbit and the error-recovery path.

Structure
REQ-038 A package ldtu_fsm_pkg SHALL hold the encoding state codes (4-bit), the fallback state codes (3-bit) and the default parameter values.
REQ-039 The fallback FSM SHALL be a sub-module ldtu_fsm_fb, instantiated once.

Verification
REQ-040 Run length: defaults, flag=1 held for 12 cycles from IDLE -> BAS with idx 0,1,2,3,4,0,1,2,3,4,0,1.
REQ-041 Orbit handling: Orbit pulse while in BAS idx 3 with flag=1 -> BC0, then HDR_B, then BAS idx 0; orbit_cnt goes 0->1.
REQ-042 Signal group: SIG_RUN=3 with flag=0 -> SIGN idx 0,1,2,0; flag=1 at idx 1 -> SIGN_BIS, then BAS idx 0.
REQ-043 Fallback: FB_LAT=3 with fallback=1 -> FB_IDLE, DATA_ODD, LAT1 x3, DATA_EVEN, LAT2 x3, DATA_ODD; state stays IDLE throughout.
REQ-044 Error injection: force state=4'hF -> seu_error=1 for 1 cycle, then state=IDLE.
REQ-045 Reset mid-operation: reset asserted during LAT2 with orbit_cnt=7 -> all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/ldtu_fsm_pkg.sv
// LDTU FSM shared definitions.
// State codes and default run parameters.
package ldtu_fsm_pkg;

  localparam int DEF_BAS_RUN = 5;
  localparam int DEF_SIG_RUN = 2;
  localparam int DEF_FB_LAT  = 1;
  localparam int DEF_OCW     = 12;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_BAS      = 4'd1;
  localparam logic [3:0] S_BAS_BIS  = 4'd2;
  localparam logic [3:0] S_SIGN     = 4'd3;
  localparam logic [3:0] S_SIGN_BIS = 4'd4;
  localparam logic [3:0] S_BC0      = 4'd5;
  localparam logic [3:0] S_BC0_S    = 4'd6;
  localparam logic [3:0] S_BC0_BIS  = 4'd7;
  localparam logic [3:0] S_HDR      = 4'd8;
  localparam logic [3:0] S_HDR_S    = 4'd9;
  localparam logic [3:0] S_HDR_B    = 4'd10;

  localparam logic [2:0] FB_IDLE      = 3'd0;
  localparam logic [2:0] FB_DATA_ODD  = 3'd1;
  localparam logic [2:0] FB_LAT1      = 3'd2;
  localparam logic [2:0] FB_DATA_EVEN = 3'd3;
  localparam logic [2:0] FB_LAT2      = 3'd4;

endpackage

// File: rtl/ldtu_fsm_fb.sv
// LDTU fallback FSM: alternating data words
// separated by FB_LAT idle cycles.
module ldtu_fsm_fb
  import ldtu_fsm_pkg::*;
#(
  parameter int FB_LAT = DEF_FB_LAT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [2:0] o_state,
  output logic [2:0] o_lat_cnt,
  output logic       o_err
);

  localparam logic [2:0] L_LAST = 3'(FB_LAT - 1);

  logic [2:0] r_state;
  logic [2:0] r_cnt;
  logic [2:0] w_nstate;
  logic [2:0] w_ncnt;
  logic       w_err;
  logic       w_lat;

  assign w_lat = (r_state == FB_LAT1) ||
                 (r_state == FB_LAT2);

  always_comb begin
    w_nstate = FB_IDLE;
    w_ncnt   = 3'd0;
    w_err    = 1'b0;
    case (r_state)
      FB_IDLE:      w_nstate = FB_DATA_ODD;
      FB_DATA_ODD:  w_nstate = FB_LAT1;
      FB_LAT1: begin
        if (r_cnt == L_LAST) begin
          w_nstate = FB_DATA_EVEN;
        end else begin
          w_nstate = FB_LAT1;
          w_ncnt   = r_cnt + 3'd1;
        end
      end
      FB_DATA_EVEN: w_nstate = FB_LAT2;
      FB_LAT2: begin
        if (r_cnt == L_LAST) begin
          w_nstate = FB_DATA_ODD;
        end else begin
          w_nstate = FB_LAT2;
          w_ncnt   = r_cnt + 3'd1;
        end
      end
      default:      w_err = 1'b1;
    endcase
    // counter out of range is treated as an upset
    if (w_lat ? (r_cnt > L_LAST) : (r_cnt != 3'd0))
      w_err = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FB_IDLE;
      r_cnt   <= 3'd0;
    end else if (w_err || !i_en) begin
      r_state <= FB_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  assign o_state   = r_state;
  assign o_lat_cnt = r_cnt;
  assign o_err     = w_err;

endmodule

// File: rtl/ldtu_fsm_param.sv
// LDTU encoding FSM with orbit header insertion,
// plus the fallback FSM selected by 'fallback'.
module ldtu_fsm_param
  import ldtu_fsm_pkg::*;
#(
  parameter int BAS_RUN = DEF_BAS_RUN,
  parameter int SIG_RUN = DEF_SIG_RUN,
  parameter int FB_LAT  = DEF_FB_LAT,
  parameter int OCW     = DEF_OCW
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           fallback,
  input  logic           Orbit,
  input  logic           baseline_flag,
  output logic [3:0]     state,
  output logic [3:0]     word_idx,
  output logic [2:0]     fb_state,
  output logic [2:0]     fb_lat_cnt,
  output logic [OCW-1:0] orbit_cnt,
  output logic           seu_error
);

  localparam logic [4:0] L_BAS = 5'(BAS_RUN);
  localparam logic [4:0] L_SIG = 5'(SIG_RUN);

  logic [3:0]     r_state;
  logic [3:0]     r_idx;
  logic [OCW-1:0] r_orb;
  logic           r_seu;
  logic [3:0]     w_nstate;
  logic [3:0]     w_nidx;
  logic           w_inc;
  logic           w_err;
  logic           w_fb_err;
  logic [4:0]     w_idx5;
  logic           w_flag;

  assign w_idx5 = {1'b0, r_idx};
  assign w_flag = baseline_flag;

  always_comb begin
    w_nstate = S_IDLE;
    w_nidx   = 4'd0;
    w_inc    = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Orbit) begin
          w_nstate = S_HDR;
          w_inc    = 1'b1;
        end else begin
          w_nstate = w_flag ? S_BAS : S_SIGN;
        end
      end
      S_BAS: begin
        w_err = (w_idx5 >= L_BAS);
        if (Orbit) begin
          w_nstate = S_BC0;
          w_inc    = 1'b1;
        end else if (w_flag) begin
          w_nstate = S_BAS;
          if (w_idx5 != L_BAS - 5'd1)
            w_nidx = r_idx + 4'd1;
        end else begin
          w_nstate = S_BAS_BIS;
        end
      end
      S_BAS_BIS: begin
        if (Orbit) begin
          w_nstate = S_BC0_BIS;
          w_inc    = 1'b1;
        end else begin
          w_nstate = w_flag ? S_SIGN_BIS : S_SIGN;
        end
      end
      S_SIGN: begin
        w_err = (w_idx5 >= L_SIG);
        if (Orbit) begin
          w_inc    = 1'b1;
          w_nstate = (w_idx5 == L_SIG - 5'd1) ?
                     S_BC0_BIS : S_BC0_S;
        end else if (!w_flag) begin
          w_nstate = S_SIGN;
          if (w_idx5 != L_SIG - 5'd1)
            w_nidx = r_idx + 4'd1;
        end else begin
          w_nstate = S_SIGN_BIS;
        end
      end
      S_SIGN_BIS: begin
        if (Orbit) begin
          w_nstate = S_BC0;
          w_inc    = 1'b1;
        end else begin
          w_nstate = w_flag ? S_BAS : S_BAS_BIS;
        end
      end
      S_BC0, S_BC0_BIS:
        w_nstate = w_flag ? S_HDR_B : S_HDR_S;
      S_BC0_S:
        w_nstate = S_HDR;
      S_HDR:
        w_nstate = w_flag ? S_BAS : S_SIGN;
      S_HDR_S:
        w_nstate = w_flag ? S_SIGN_BIS : S_SIGN;
      S_HDR_B:
        w_nstate = w_flag ? S_BAS : S_BAS_BIS;
      default:
        w_err = 1'b1;
    endcase
    // only grouped states may carry a non-zero index
    if (r_state != S_BAS && r_state != S_SIGN &&
        r_idx != 4'd0)
      w_err = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_orb   <= '0;
      r_seu   <= 1'b0;
    end else begin
      r_seu <= w_err | w_fb_err;
      if (w_err || fallback) begin
        r_state <= S_IDLE;
        r_idx   <= 4'd0;
      end else begin
        r_state <= w_nstate;
        r_idx   <= w_nidx;
        if (w_inc)
          r_orb <= r_orb + 1'b1;
      end
    end
  end

  ldtu_fsm_fb #(
    .FB_LAT (FB_LAT)
  ) u_fb (
    .i_clk     (CLK),
    .i_rst     (reset),
    .i_en      (fallback),
    .o_state   (fb_state),
    .o_lat_cnt (fb_lat_cnt),
    .o_err     (w_fb_err)
  );

  assign state     = r_state;
  assign word_idx  = r_idx;
  assign orbit_cnt = r_orb;
  assign seu_error = r_seu;

endmodule

// File: tb/tb_ldtu_fsm_param.sv
// Directed bench for ldtu_fsm_param
// (BAS_RUN=5, SIG_RUN=3, FB_LAT=3).
module tb_ldtu_fsm_param;
  import ldtu_fsm_pkg::*;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        fallback = 1'b0;
  logic        Orbit = 1'b0;
  logic        baseline_flag = 1'b0;
  logic [3:0]  state;
  logic [3:0]  word_idx;
  logic [2:0]  fb_state;
  logic [2:0]  fb_lat_cnt;
  logic [11:0] orbit_cnt;
  logic        seu_error;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  ldtu_fsm_param #(
    .BAS_RUN (5),
    .SIG_RUN (3),
    .FB_LAT  (3),
    .OCW     (12)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .fallback      (fallback),
    .Orbit         (Orbit),
    .baseline_flag (baseline_flag),
    .state         (state),
    .word_idx      (word_idx),
    .fb_state      (fb_state),
    .fb_lat_cnt    (fb_lat_cnt),
    .orbit_cnt     (orbit_cnt),
    .seu_error     (seu_error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic stp(input logic fb,
                     input logic o,
                     input logic f);
    fallback      = fb;
    Orbit         = o;
    baseline_flag = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic ce(input string tag,
                    input logic [3:0] es,
                    input logic [3:0] ei);
    chk({tag, "/st"}, 32'(state), 32'(es));
    chk({tag, "/idx"}, 32'(word_idx), 32'(ei));
  endtask

  task automatic chk_rst(input string tag);
    ce(tag, S_IDLE, 4'd0);
    chk({tag, "/fb"}, 32'(fb_state), 32'(FB_IDLE));
    chk({tag, "/lat"}, 32'(fb_lat_cnt), 32'd0);
    chk({tag, "/orb"}, 32'(orbit_cnt), 32'd0);
    chk({tag, "/seu"}, 32'(seu_error), 32'd0);
  endtask

  logic [3:0] run_idx [12] =
    '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
  logic [2:0] fb_exp [14] =
    '{FB_DATA_ODD, FB_LAT1, FB_LAT1, FB_LAT1,
      FB_DATA_EVEN, FB_LAT2, FB_LAT2, FB_LAT2,
      FB_DATA_ODD, FB_LAT1, FB_LAT1, FB_LAT1,
      FB_DATA_EVEN, FB_LAT2};
  logic [2:0] lat_exp [14] =
    '{0, 0, 1, 2, 0, 0, 1, 2, 0, 0, 1, 2, 0, 0};

  initial begin
    stp(0, 0, 0);
    stp(0, 0, 0);
    chk_rst("rst0");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      stp(0, 0, 1);
      ce($sformatf("run%0d", i), S_BAS, run_idx[i]);
    end
    stp(0, 0, 1);
    stp(0, 0, 1);
    ce("bas3", S_BAS, 4'd3);
    stp(0, 1, 1);
    ce("bc0", S_BC0, 4'd0);
    chk("bc0/orb", 32'(orbit_cnt), 32'd1);
    stp(0, 1, 1);
    ce("hdrb", S_HDR_B, 4'd0);
    chk("ign/orb", 32'(orbit_cnt), 32'd1);
    stp(0, 0, 1);
    ce("bas0", S_BAS, 4'd0);

    stp(0, 0, 0); ce("bbis", S_BAS_BIS, 4'd0);
    stp(0, 0, 1); ce("sbis", S_SIGN_BIS, 4'd0);
    stp(0, 0, 0); ce("bbis2", S_BAS_BIS, 4'd0);
    stp(0, 0, 0); ce("sg0", S_SIGN, 4'd0);
    stp(0, 0, 0); ce("sg1", S_SIGN, 4'd1);
    stp(0, 0, 0); ce("sg2", S_SIGN, 4'd2);
    stp(0, 0, 0); ce("sgw", S_SIGN, 4'd0);
    stp(0, 0, 0); ce("sg1b", S_SIGN, 4'd1);
    stp(0, 0, 1); ce("sbis2", S_SIGN_BIS, 4'd0);
    stp(0, 0, 1); ce("basr", S_BAS, 4'd0);

    stp(0, 0, 0); ce("bbis3", S_BAS_BIS, 4'd0);
    stp(0, 0, 0); ce("sg0b", S_SIGN, 4'd0);
    stp(0, 1, 0); ce("bc0s", S_BC0_S, 4'd0);
    chk("bc0s/orb", 32'(orbit_cnt), 32'd2);
    stp(0, 0, 1); ce("hdr", S_HDR, 4'd0);
    chk("hdr/orb", 32'(orbit_cnt), 32'd2);
    stp(0, 0, 0); ce("sg0c", S_SIGN, 4'd0);
    stp(0, 0, 0); ce("sg1c", S_SIGN, 4'd1);
    stp(0, 0, 0); ce("sg2c", S_SIGN, 4'd2);
    stp(0, 1, 0); ce("bc0b", S_BC0_BIS, 4'd0);
    chk("bc0b/orb", 32'(orbit_cnt), 32'd3);
    stp(0, 0, 0); ce("hdrs", S_HDR_S, 4'd0);
    stp(0, 0, 1); ce("sbis3", S_SIGN_BIS, 4'd0);
    stp(0, 1, 0); ce("bc0c", S_BC0, 4'd0);
    chk("bc0c/orb", 32'(orbit_cnt), 32'd4);
    stp(0, 0, 1); ce("hdrb2", S_HDR_B, 4'd0);
    stp(0, 0, 0); ce("bbis4", S_BAS_BIS, 4'd0);

    reset = 1'b1;
    stp(0, 0, 0);
    reset = 1'b0;
    chk_rst("rst1");

    for (int i = 1; i <= 18; i++) begin
      stp(0, 1, 1);
      if (i == 1) begin
        ce("o1", S_HDR, 4'd0);
        chk("o1/orb", 32'(orbit_cnt), 32'd1);
      end
    end
    ce("o18", S_BC0, 4'd0);
    chk("o18/orb", 32'(orbit_cnt), 32'd7);

    for (int i = 0; i < 14; i++) begin
      stp(1, 0, 0);
      chk($sformatf("fb%0d", i),
          32'(fb_state), 32'(fb_exp[i]));
      chk($sformatf("lat%0d", i),
          32'(fb_lat_cnt), 32'(lat_exp[i]));
      ce($sformatf("fbst%0d", i), S_IDLE, 4'd0);
    end
    chk("fb/orb", 32'(orbit_cnt), 32'd7);

    reset = 1'b1;
    stp(1, 1, 1);
    chk_rst("rst2");
    reset = 1'b0;

    stp(0, 0, 1);
    ce("pre", S_BAS, 4'd0);
    force dut.r_state = 4'hF;
    #1;
    release dut.r_state;
    stp(0, 0, 1);
    chk("seu1", 32'(seu_error), 32'd1);
    ce("seu1", S_IDLE, 4'd0);
    stp(0, 0, 1);
    chk("seu0", 32'(seu_error), 32'd0);
    ce("seu0", S_BAS, 4'd0);

    stp(1, 0, 1);
    ce("ab0", S_IDLE, 4'd0);
    chk("ab0/fb", 32'(fb_state), 32'(FB_DATA_ODD));
    stp(1, 0, 1);
    chk("ab1/fb", 32'(fb_state), 32'(FB_LAT1));
    stp(0, 0, 1);
    chk("ab2/fb", 32'(fb_state), 32'(FB_IDLE));
    chk("ab2/lat", 32'(fb_lat_cnt), 32'd0);
    ce("ab2", S_BAS, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
